// File: rtl/wrr_pkg.sv
// Shared widths, per-class scheduling state and rank packing for the WRR rank engines.
package wrr_pkg;

    localparam int CLASS_W  = 5;
    localparam int WEIGHT_W = 16;
    localparam int OVF_W    = 1;
    localparam int ROUND_W  = 18;
    localparam int ADDR_W   = 12;
    localparam int RESULT_W = 1 + OVF_W + ROUND_W + ADDR_W;

    localparam logic [ROUND_W-1:0] ROUND_MAX = '1;

    typedef struct packed {
        logic [OVF_W-1:0]    ovf;
        logic [ROUND_W-1:0]  round;
        logic [WEIGHT_W-1:0] credit;
    } class_state_t;

    function automatic logic [RESULT_W-1:0] pack_rank(input class_state_t s,
                                                      input logic [ADDR_W-1:0] addr);
        return {1'b1, s.ovf, s.round, addr};
    endfunction

endpackage

// File: rtl/wrr_rank_calc.sv
// Combinational WRR state update: (class state, weight, PIFO head snapshot) -> next class state.
module wrr_rank_calc
    import wrr_pkg::*;
#(
    parameter logic [ROUND_W-1:0] RMAX     = ROUND_MAX,
    parameter logic [OVF_W-1:0]   OVF_MASK = '1
) (
    input  class_state_t        cur,
    input  logic [WEIGHT_W-1:0] weight,
    input  logic [OVF_W-1:0]    govf,
    input  logic [ROUND_W-1:0]  grnd,
    output class_state_t        nxt
);

    logic [WEIGHT_W-1:0] refill;

    always_comb begin
        // A zero weight refills as if it were one: credit w-1 == 0.
        refill = (weight == '0) ? '0 : weight - WEIGHT_W'(1);
        nxt    = cur;
        if (cur.ovf != govf && grnd < cur.round) begin
            nxt.ovf    = govf;
            nxt.round  = grnd;
            nxt.credit = refill;
        end else if (cur.ovf == govf && cur.round < grnd) begin
            nxt.round  = grnd;
            nxt.credit = refill;
        end else if (cur.credit != '0) begin
            nxt.credit = cur.credit - WEIGHT_W'(1);
        end else if (cur.round == RMAX) begin
            nxt.ovf    = (cur.ovf + OVF_W'(1)) & OVF_MASK;
            nxt.round  = '0;
            nxt.credit = refill;
        end else begin
            nxt.round  = cur.round + ROUND_W'(1);
            nxt.credit = refill;
        end
    end

endmodule

// File: rtl/wrr_rank_engine_bp.sv
// WRR rank engine: 3-stage pipeline with per-class state/weight tables, same-class bypass
// and ready/valid backpressure. Width overrides must not exceed the wrr_pkg widths.
module wrr_rank_engine_bp
    import wrr_pkg::*;
#(
    parameter int CLASS_WIDTH         = CLASS_W,
    parameter int WEIGHT_WIDTH        = WEIGHT_W,
    parameter int PIFO_OVERFLOW_WIDTH = OVF_W,
    parameter int PIFO_ROUND_WIDTH    = ROUND_W,
    parameter int PIFO_ADDR_WIDTH     = ADDR_W,
    parameter int RESULT_WIDTH        = 1 + PIFO_OVERFLOW_WIDTH + PIFO_ROUND_WIDTH + PIFO_ADDR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [CLASS_WIDTH-1:0]         req_class_id,
    input  logic [PIFO_ADDR_WIDTH-1:0]     req_addr,
    input  logic                           last_pifo_valid,
    input  logic [PIFO_OVERFLOW_WIDTH-1:0] last_pifo_overflow,
    input  logic [PIFO_ROUND_WIDTH-1:0]    last_pifo_round,
    input  logic                           cfg_wr_en,
    input  logic                           cfg_clear,
    input  logic [CLASS_WIDTH-1:0]         cfg_class_id,
    input  logic [WEIGHT_WIDTH-1:0]        cfg_weight,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [RESULT_WIDTH-1:0]        resp_data
);

    localparam int                 CLASS_COUNT = 2 ** CLASS_WIDTH;
    localparam logic [ROUND_W-1:0] RMAX        = ROUND_W'((1 << PIFO_ROUND_WIDTH) - 1);
    localparam logic [OVF_W-1:0]   OMASK       = OVF_W'((1 << PIFO_OVERFLOW_WIDTH) - 1);

    // Handshake: a request moves on clk when req_valid & req_ready; a rank leaves on clk
    // when resp_valid & resp_ready; while resp_valid & ~resp_ready the whole pipe holds.
    logic stall, adv, wb_en, bypass;

    logic                       s1_valid_q, s1_valid_d;
    logic [CLASS_WIDTH-1:0]     s1_class_q, s1_class_d;
    logic [PIFO_ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;

    logic                       s2_valid_q, s2_valid_d;
    logic [CLASS_WIDTH-1:0]     s2_class_q, s2_class_d;
    logic [PIFO_ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
    class_state_t               s2_state_q, s2_state_d;
    logic [WEIGHT_W-1:0]        s2_weight_q, s2_weight_d;

    logic                       resp_valid_q, resp_valid_d;
    logic [RESULT_WIDTH-1:0]    resp_data_q, resp_data_d;

    logic [OVF_W-1:0]           g_ovf_q, g_ovf_d;
    logic [ROUND_W-1:0]         g_rnd_q, g_rnd_d;

    class_state_t               tbl_q [CLASS_COUNT];
    class_state_t               tbl_d [CLASS_COUNT];
    logic [WEIGHT_W-1:0]        wt_q [CLASS_COUNT];
    logic [WEIGHT_W-1:0]        wt_d [CLASS_COUNT];

    class_state_t               s2_next;
    logic [RESULT_WIDTH-1:0]    rank_word;

    wrr_rank_calc #(
        .RMAX     (RMAX),
        .OVF_MASK (OMASK)
    ) u_calc (
        .cur    (s2_state_q),
        .weight (s2_weight_q),
        .govf   (g_ovf_q),
        .grnd   (g_rnd_q),
        .nxt    (s2_next)
    );

    if (PIFO_OVERFLOW_WIDTH == OVF_W && PIFO_ROUND_WIDTH == ROUND_W && PIFO_ADDR_WIDTH == ADDR_W)
    begin : g_pkg_pack
        assign rank_word = pack_rank(s2_next, s2_addr_q);
    end else begin : g_narrow_pack
        assign rank_word = {1'b1, s2_next.ovf[PIFO_OVERFLOW_WIDTH-1:0],
                            s2_next.round[PIFO_ROUND_WIDTH-1:0], s2_addr_q};
    end

    always_comb begin
        stall  = resp_valid_q & ~resp_ready;
        adv    = ~stall;
        wb_en  = adv & s2_valid_q;
        // S2 writes its result on this same edge, so a trailing same-class request takes it directly.
        bypass = adv & s1_valid_q & s2_valid_q & (s2_class_q == s1_class_q);

        s1_valid_d   = s1_valid_q;
        s1_class_d   = s1_class_q;
        s1_addr_d    = s1_addr_q;
        s2_valid_d   = s2_valid_q;
        s2_class_d   = s2_class_q;
        s2_addr_d    = s2_addr_q;
        s2_state_d   = s2_state_q;
        s2_weight_d  = s2_weight_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        if (adv) begin
            s1_valid_d   = req_valid;
            s1_class_d   = req_class_id;
            s1_addr_d    = req_addr;
            s2_valid_d   = s1_valid_q;
            s2_class_d   = s1_class_q;
            s2_addr_d    = s1_addr_q;
            s2_state_d   = bypass ? s2_next : tbl_q[s1_class_q];
            s2_weight_d  = wt_q[s1_class_q];
            resp_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                resp_data_d = rank_word;
            end
        end

        g_ovf_d = g_ovf_q;
        g_rnd_d = g_rnd_q;
        if (last_pifo_valid) begin
            g_ovf_d = OVF_W'(last_pifo_overflow);
            g_rnd_d = ROUND_W'(last_pifo_round);
        end

        // Clear is applied after writeback so it wins on a same-class collision.
        tbl_d = tbl_q;
        if (wb_en) begin
            tbl_d[s2_class_q] = s2_next;
        end
        if (cfg_clear) begin
            tbl_d[cfg_class_id] = '0;
        end

        wt_d = wt_q;
        if (cfg_wr_en) begin
            wt_d[cfg_class_id] = WEIGHT_W'(cfg_weight);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q   <= 1'b0;
            s1_class_q   <= '0;
            s1_addr_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_class_q   <= '0;
            s2_addr_q    <= '0;
            s2_state_q   <= '0;
            s2_weight_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            g_ovf_q      <= '0;
            g_rnd_q      <= '0;
            for (int i = 0; i < CLASS_COUNT; i++) begin
                tbl_q[i] <= '0;
                wt_q[i]  <= '0;
            end
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_class_q   <= s1_class_d;
            s1_addr_q    <= s1_addr_d;
            s2_valid_q   <= s2_valid_d;
            s2_class_q   <= s2_class_d;
            s2_addr_q    <= s2_addr_d;
            s2_state_q   <= s2_state_d;
            s2_weight_q  <= s2_weight_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            g_ovf_q      <= g_ovf_d;
            g_rnd_q      <= g_rnd_d;
            tbl_q        <= tbl_d;
            wt_q         <= wt_d;
        end
    end

    assign req_ready  = adv;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_wrr_rank_engine_bp.sv
// Bench for wrr_rank_engine_bp: per-class model updated at request acceptance, in-order
// expected queue checked on every response handshake, plus literal rank expectations.
module tb_wrr_rank_engine_bp;

    localparam int RMAX = (1 << 18) - 1;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready;
    logic [4:0]  req_class_id;
    logic [11:0] req_addr;
    logic        last_pifo_valid;
    logic [0:0]  last_pifo_overflow;
    logic [17:0] last_pifo_round;
    logic        cfg_wr_en, cfg_clear;
    logic [4:0]  cfg_class_id;
    logic [15:0] cfg_weight;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;

    // Narrow-round instance (2-bit round field, ROUND_MAX = 3)
    logic        req_valid_b, req_ready_b, cfg_wr_en_b, resp_valid_b;
    logic [11:0] req_addr_b;
    logic [15:0] resp_data_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [15:0] got_b_q[$];

    int m_ovf[32], m_rnd[32], m_cr[32], m_w[32];
    int g_ovf, g_rnd;

    logic        prev_hold;
    logic [31:0] prev_data;

    always #5 clk = ~clk;

    wrr_rank_engine_bp dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_class_id(req_class_id), .req_addr(req_addr),
        .last_pifo_valid(last_pifo_valid), .last_pifo_overflow(last_pifo_overflow),
        .last_pifo_round(last_pifo_round),
        .cfg_wr_en(cfg_wr_en), .cfg_clear(cfg_clear), .cfg_class_id(cfg_class_id),
        .cfg_weight(cfg_weight),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data)
    );

    wrr_rank_engine_bp #(.PIFO_ROUND_WIDTH(2)) dut_b (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_class_id(5'd0), .req_addr(req_addr_b),
        .last_pifo_valid(1'b0), .last_pifo_overflow(1'b0), .last_pifo_round(2'd0),
        .cfg_wr_en(cfg_wr_en_b), .cfg_clear(1'b0), .cfg_class_id(5'd0),
        .cfg_weight(16'd1),
        .resp_valid(resp_valid_b), .resp_ready(1'b1), .resp_data(resp_data_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int o, input int r, input int a);
        return {1'b1, 1'(o), 18'(r), 12'(a)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_ovf[i] = 0; m_rnd[i] = 0; m_cr[i] = 0; m_w[i] = 0;
        end
        g_ovf = 0;
        g_rnd = 0;
    endtask

    // Rank rules applied per accepted request, in acceptance order.
    task automatic model_accept(input int c, input int a);
        int w;
        w = (m_w[c] == 0) ? 1 : m_w[c];
        if (m_ovf[c] != g_ovf && g_rnd < m_rnd[c]) begin
            m_ovf[c] = g_ovf; m_rnd[c] = g_rnd; m_cr[c] = w - 1;
        end else if (m_ovf[c] == g_ovf && m_rnd[c] < g_rnd) begin
            m_rnd[c] = g_rnd; m_cr[c] = w - 1;
        end else if (m_cr[c] > 0) begin
            m_cr[c] = m_cr[c] - 1;
        end else if (m_rnd[c] == RMAX) begin
            m_ovf[c] = (m_ovf[c] + 1) % 2; m_rnd[c] = 0; m_cr[c] = w - 1;
        end else begin
            m_rnd[c] = m_rnd[c] + 1; m_cr[c] = w - 1;
        end
        exp_q.push_back(mk(m_ovf[c], m_rnd[c], a));
    endtask

    task automatic send(input int cls, input int addr);
        req_valid    = 1'b1;
        req_class_id = 5'(cls);
        req_addr     = 12'(addr);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                model_accept(cls, addr);
                @(posedge clk); #1;
                req_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        n_tests++; n_fail++;
        $display("FAIL send_timeout: class %0d never accepted", cls);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: %0d ranks outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input int cls, input int w);
        cfg_wr_en = 1'b1; cfg_class_id = 5'(cls); cfg_weight = 16'(w);
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
        m_w[cls] = w;
    endtask

    task automatic snapshot(input int o, input int r);
        last_pifo_valid = 1'b1; last_pifo_overflow = 1'(o); last_pifo_round = 18'(r);
        @(posedge clk); #1;
        last_pifo_valid = 1'b0;
        g_ovf = o; g_rnd = r;
    endtask

    task automatic check_got(input string name, input int idx, input logic [31:0] exp);
        if (idx < got_q.size()) begin
            check(name, got_q[idx], exp);
        end else begin
            n_tests++; n_fail++;
            $display("FAIL %s: rank %0d missing, expected 0x%0h", name, idx, exp);
        end
    endtask

    // Every handshake is checked against the model queue; held ranks must stay stable.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_hold = 1'b0;
        end else begin
            check("req_ready_rule", req_ready, !(resp_valid && !resp_ready));
            if (prev_hold) begin
                check("hold_valid", resp_valid, 1'b1);
                check("hold_data", resp_data, prev_data);
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_rank: got 0x%0h, expected none", resp_data);
                end else begin
                    check("rank", resp_data, exp_q.pop_front());
                end
                got_q.push_back(resp_data);
                prev_hold = 1'b0;
            end else if (resp_valid) begin
                prev_hold = 1'b1;
                prev_data = resp_data;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && resp_valid_b) got_b_q.push_back(resp_data_b);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        req_valid = 0; req_class_id = 0; req_addr = 0;
        last_pifo_valid = 0; last_pifo_overflow = 0; last_pifo_round = 0;
        cfg_wr_en = 0; cfg_clear = 0; cfg_class_id = 0; cfg_weight = 0;
        resp_ready = 1'b1;
        req_valid_b = 0; req_addr_b = 0; cfg_wr_en_b = 0;
        model_reset();
        repeat (3) @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("reset_resp_valid", resp_valid, 1'b0);
        check("reset_resp_data", resp_data, 32'h0);
        check("reset_req_ready", req_ready, 1'b1);
        @(posedge clk); #1;

        // Weight 3, back-to-back same class: bypass path
        cfg_write(2, 3);
        got_q.delete();
        for (int i = 0; i < 4; i++) send(2, 'h10 + i);
        drain();
        check_got("t1_r0", 0, mk(0, 1, 'h10));
        check_got("t1_r1", 1, mk(0, 1, 'h11));
        check_got("t1_r2", 2, mk(0, 1, 'h12));
        check_got("t1_r3", 3, mk(0, 2, 'h13));

        // Snapshot jump: class 5 at round 1, G round 5
        cfg_write(5, 2);
        got_q.delete();
        send(5, 'h20);
        drain();
        snapshot(0, 5);
        send(5, 'h21); send(5, 'h22); send(5, 'h23);
        drain();
        check_got("t2_r0", 0, mk(0, 1, 'h20));
        check_got("t2_jump", 1, 32'h8000_5021);
        check_got("t2_r2", 2, mk(0, 5, 'h22));
        check_got("t2_r3", 3, mk(0, 6, 'h23));

        // Backpressure: 3 stalled cycles while 4 requests stream
        cfg_write(3, 3);
        got_q.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) send(3, 'h30 + i);
            end
            begin
                repeat (3) @(posedge clk); #1;
                resp_ready = 1'b0;
                @(negedge clk);
                check("stall_resp_valid", resp_valid, 1'b1);
                check("stall_req_ready", req_ready, 1'b0);
                repeat (3) @(posedge clk); #1;
                resp_ready = 1'b1;
            end
        join
        drain();
        check_got("t3_r0", 0, mk(0, 5, 'h30));
        check_got("t3_r1", 1, mk(0, 5, 'h31));
        check_got("t3_r2", 2, mk(0, 5, 'h32));
        check_got("t3_r3", 3, mk(0, 6, 'h33));

        // Epoch change: G ovf differs and grnd below class round
        got_q.delete();
        snapshot(1, 3);
        send(5, 'h60);
        drain();
        check_got("t_epoch", 0, mk(1, 3, 'h60));

        // cfg_clear colliding with the S2 writeback of class 2
        snapshot(0, 0);
        got_q.delete();
        send(2, 'h40);
        @(posedge clk); #1;
        cfg_clear = 1'b1; cfg_class_id = 5'd2;
        @(posedge clk); #1;
        cfg_clear = 1'b0;
        m_ovf[2] = 0; m_rnd[2] = 0; m_cr[2] = 0;
        drain();
        send(2, 'h41);
        drain();
        check_got("t4_pre_clear", 0, mk(0, 2, 'h40));
        check_got("t4_post_clear", 1, mk(0, 1, 'h41));

        // Weight 0 refills like weight 1
        got_q.delete();
        send(7, 'h70); send(7, 'h71); send(7, 'h72);
        drain();
        check_got("t_w0_r0", 0, mk(0, 1, 'h70));
        check_got("t_w0_r1", 1, mk(0, 2, 'h71));
        check_got("t_w0_r2", 2, mk(0, 3, 'h72));

        // Reset with two requests in flight
        send(7, 'h50); send(7, 'h51);
        rstn = 1'b0;
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk); #1;
        rstn = 1'b1;
        got_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_quiet", resp_valid, 1'b0);
        end
        @(posedge clk); #1;
        send(7, 'h52);
        drain();
        check_got("t5_after_reset", 0, mk(0, 1, 'h52));

        // 2-bit round field: wrap into the overflow epoch
        cfg_wr_en_b = 1'b1;
        @(posedge clk); #1;
        cfg_wr_en_b = 1'b0;
        got_b_q.delete();
        for (int i = 0; i < 4; i++) begin
            req_valid_b = 1'b1; req_addr_b = 12'(i);
            @(posedge clk); #1;
        end
        req_valid_b = 1'b0;
        repeat (6) @(posedge clk); #1;
        check("tb_count", got_b_q.size(), 4);
        if (got_b_q.size() == 4) begin
            check("tb_r0", got_b_q[0], 16'h9000);
            check("tb_r1", got_b_q[1], 16'hA001);
            check("tb_r2", got_b_q[2], 16'hB002);
            check("tb_r3", got_b_q[3], 16'hC003);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
